// File: rtl/shiftreg_in_if.sv
// shiftreg_in_if: host/serial-side signal bundle of the SPI bridge receive
// shift register.
//   read_rq    host -> rx : level request to receive one byte (rising edge)
//   data_rq    host -> rx : acknowledge of the presented byte
//   serclk     ext  -> rx : slow serial bit clock, asynchronous to clk
//   ser_in     ext  -> rx : serial data, valid on the rising edge of serclk
//   data       rx -> host : last completed byte
//   data_ready rx -> host : completed, unacknowledged byte on data
//   busy       rx -> host : reception in progress
// master = host/driver side, slave = receiver side.
`timescale 1ns/1ps
interface shiftreg_in_if #(
    parameter int WIDTH = 8
);
    logic             read_rq;
    logic             data_rq;
    logic             serclk;
    logic             ser_in;
    logic [WIDTH-1:0] data;
    logic             data_ready;
    logic             busy;

    modport master (
        output read_rq, data_rq, serclk, ser_in,
        input  data, data_ready, busy
    );

    modport slave (
        input  read_rq, data_rq, serclk, ser_in,
        output data, data_ready, busy
    );
endinterface

// File: rtl/shiftreg_in.sv
// shiftreg_in: serial-to-parallel receive shift register.
// A rising edge on read_rq arms the capture of WIDTH bits of ser_in, taken
// MSB first on rising edges of serclk. serclk and ser_in are brought into the
// clk domain through equal-length synchronisers, so the data sample stays
// aligned with the detected clock edge. The completed byte is held on data
// with data_ready until the host acknowledges it with data_rq.
// Ports:
//   clk    : system clock, all state changes on its rising edge
//   reset  : synchronous, active-low reset
//   bus    : shiftreg_in_if slave modport (read_rq, data_rq, serclk, ser_in,
//            data, data_ready, busy); interface WIDTH must match WIDTH here
`timescale 1ns/1ps
module shiftreg_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    shiftreg_in_if.slave bus
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READY = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] serclk_sync_r;
    logic [SYNC_STAGES-1:0] ser_in_sync_r;
    logic                   serclk_prev_r;
    logic                   read_rq_r;
    logic                   read_rq_prev_r;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [WIDTH-1:0]       shift_r;
    logic [WIDTH-1:0]       data_r;
    logic                   data_ready_r;
    logic                   busy_r;

    logic                   rise_s;
    logic                   start_s;
    logic [WIDTH-1:0]       next_shift_s;

    // Both synchronisers have the same depth, so the ser_in sample seen with
    // a detected serclk rise is the one taken alongside that rise.
    assign rise_s       = serclk_sync_r[SYNC_STAGES-1] & ~serclk_prev_r;
    assign start_s      = read_rq_r & ~read_rq_prev_r;
    assign next_shift_s = {shift_r[WIDTH-2:0], ser_in_sync_r[SYNC_STAGES-1]};

    assign bus.data       = data_r;
    assign bus.data_ready = data_ready_r;
    assign bus.busy       = busy_r;

    // Input synchronisers and edge-detect history for serclk and read_rq.
    always_ff @(posedge clk) begin
        if (!reset) begin
            serclk_sync_r  <= {SYNC_STAGES{1'b0}};
            ser_in_sync_r  <= {SYNC_STAGES{1'b0}};
            serclk_prev_r  <= 1'b0;
            read_rq_r      <= 1'b0;
            read_rq_prev_r <= 1'b0;
        end else begin
            serclk_sync_r  <= {serclk_sync_r[SYNC_STAGES-2:0], bus.serclk};
            ser_in_sync_r  <= {ser_in_sync_r[SYNC_STAGES-2:0], bus.ser_in};
            serclk_prev_r  <= serclk_sync_r[SYNC_STAGES-1];
            read_rq_r      <= bus.read_rq;
            read_rq_prev_r <= read_rq_r;
        end
    end

    // Receive state machine with registered data/data_ready/busy outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            shift_r      <= {WIDTH{1'b0}};
            data_r       <= {WIDTH{1'b0}};
            data_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (start_s) begin
                        state_r      <= ST_SHIFT;
                        busy_r       <= 1'b1;
                        cnt_r        <= {CNT_W{1'b0}};
                        shift_r      <= {WIDTH{1'b0}};
                        data_ready_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // read_rq and data_rq are deliberately not looked at here.
                    if (rise_s) begin
                        shift_r <= next_shift_s;
                        if (cnt_r == LAST_CNT) begin
                            data_r       <= next_shift_s;
                            data_ready_r <= 1'b1;
                            busy_r       <= 1'b0;
                            cnt_r        <= {CNT_W{1'b0}};
                            state_r      <= ST_READY;
                        end else begin
                            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_READY: begin
                    // A new request takes priority over the acknowledge.
                    if (start_s) begin
                        state_r      <= ST_SHIFT;
                        busy_r       <= 1'b1;
                        cnt_r        <= {CNT_W{1'b0}};
                        shift_r      <= {WIDTH{1'b0}};
                        data_ready_r <= 1'b0;
                    end else if (bus.data_rq) begin
                        data_ready_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    data_ready_r <= 1'b0;
                    cnt_r        <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_in.sv
`timescale 1ns/1ps
module tb_shiftreg_in;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [7:0] exp_q[$];
    logic [7:0] last_byte;
    logic       mon_dr_prev;
    logic       in_ready;

    shiftreg_in_if #(.WIDTH(8)) bus ();

    shiftreg_in #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every new data_ready must match the next expected byte.
    always @(negedge clk) begin
        if (bus.data_ready === 1'b1 && mon_dr_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("byte_data", {24'd0, bus.data}, {24'd0, e});
                chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
            end
        end
        mon_dr_prev <= bus.data_ready;
    end

    // One serial bit: data set up while serclk is low, then a rising edge.
    task automatic send_bit(input logic b);
        bus.ser_in = b;
        bus.serclk = 1'b0;
        #400;
        bus.serclk = 1'b1;
        #400;
    endtask

    // Send bits first..last (index 0 = MSB) of b; the expected byte is queued
    // just before the final rise is driven.
    task automatic send_bits(input logic [7:0] b, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            if (k == 7) exp_q.push_back(b);
            send_bit(b[7-k]);
        end
    endtask

    task automatic start_read();
        @(posedge clk); #1;
        bus.read_rq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.read_rq = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        bus.data_rq = 1'b1;
        @(posedge clk); #1;
        bus.data_rq = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input logic [7:0] b);
        int n;
        n = 0;
        while (bus.data_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'd0, bus.data_ready}, 32'd1);
        last_byte = b;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        checks = 0;
        errors = 0;
        mon_dr_prev = 1'b0;
        last_byte = 8'h00;
        reset = 1'b0;
        bus.read_rq = 1'b0;
        bus.data_rq = 1'b0;
        bus.serclk = 1'b1;
        bus.ser_in = 1'b0;

        // Reset held 3 clocks with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.read_rq = 1'($urandom_range(0, 1));
            bus.data_rq = 1'($urandom_range(0, 1));
            bus.serclk  = 1'($urandom_range(0, 1));
            bus.ser_in  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_data", {24'd0, bus.data}, 32'd0);
            chk("rst_ready", {31'd0, bus.data_ready}, 32'd0);
            chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        end
        bus.read_rq = 1'b0;
        bus.data_rq = 1'b0;
        bus.serclk  = 1'b1;
        bus.ser_in  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // Byte 0xAA.
        start_read();
        chk("aa_busy_start", {31'd0, bus.busy}, 32'd1);
        send_bits(8'hAA, 0, 3);
        chk("aa_busy_mid", {31'd0, bus.busy}, 32'd1);
        chk("aa_data_mid", {24'd0, bus.data}, 32'd0);
        send_bits(8'hAA, 4, 7);
        wait_ready(8'hAA);
        chk("aa_busy_end", {31'd0, bus.busy}, 32'd0);

        // Acknowledge, then byte 0x55 with data stable during shifting.
        ack();
        chk("ack_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("ack_data", {24'd0, bus.data}, 32'hAA);
        start_read();
        send_bits(8'h55, 0, 6);
        chk("55_data_hold", {24'd0, bus.data}, 32'hAA);
        chk("55_ready_low", {31'd0, bus.data_ready}, 32'd0);
        send_bits(8'h55, 7, 7);
        wait_ready(8'h55);
        ack();

        // Ignored read_rq and data_rq during SHIFT.
        start_read();
        send_bits(8'hC3, 0, 3);
        start_read();
        chk("ign_busy", {31'd0, bus.busy}, 32'd1);
        ack();
        chk("ign_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("ign_busy2", {31'd0, bus.busy}, 32'd1);
        send_bits(8'hC3, 4, 7);
        wait_ready(8'hC3);
        ack();

        // Mid-transfer reset.
        start_read();
        b = 8'($urandom);
        send_bits(b, 0, 4);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_data", {24'd0, bus.data}, 32'd0);
        chk("mrst_ready", {31'd0, bus.data_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        last_byte = 8'h00;
        repeat (2) @(posedge clk);
        start_read();
        b = 8'($urandom);
        send_bits(b, 0, 7);
        wait_ready(b);
        ack();

        // Idle serclk activity with no request.
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (5) @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("idle_data", {24'd0, bus.data}, {24'd0, last_byte});

        // Random bytes, randomly acknowledged or restarted straight from READY.
        in_ready = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (in_ready && $urandom_range(0, 1) == 1) begin
                start_read();
                chk("rdy_restart_ready", {31'd0, bus.data_ready}, 32'd0);
                chk("rdy_restart_busy", {31'd0, bus.busy}, 32'd1);
            end else begin
                if (in_ready) ack();
                start_read();
            end
            b = 8'($urandom);
            send_bits(b, 0, 5);
            chk("rnd_data_hold", {24'd0, bus.data}, {24'd0, last_byte});
            send_bits(b, 6, 7);
            wait_ready(b);
            in_ready = 1'b1;
        end
        ack();
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
